// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Consumer end of the system PLL's rst/locked handshake. Pulses the PLL's
//   reset, waits for lock, and then requires lock to stay continuously
//   asserted for a while before releasing the design-wide sys_reset. If lock
//   never arrives in time, or if lock is lost while running, the PLL is reset
//   again. Runs on the free-running board clock so that it keeps working
//   while the PLL is unlocked.
//
// Parameters:
//   RST_CYCLES     cycles pll_rst is held high per PLL reset pulse (>=1)
//   LOCK_TIMEOUT   max cycles spent waiting for lock before re-resetting (>=2)
//   STABLE_CYCLES  consecutive locked cycles needed before release (>=1)
//
// Ports:
//   clk           in   free-running reference clock
//   reset         in   asynchronous, active-high reset
//   pll_locked    in   PLL locked flag, asynchronous to clk
//   pll_rst       out  active-high reset to the PLL
//   sys_reset     out  active-high system reset (async assert, sync release)
//   ready         out  high only while running (== ~sys_reset)
//   relock_count  out  saturating count of lock losses seen while running
//
// Configuration macro:
//   PLL_RELOCK_COUNT_EN  when defined, relock_count counts RUN->PLL_RESET
//                        transitions and saturates at 255; when undefined
//                        there are no counter flops and it reads 8'h00.
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic [7:0] relock_count
);

   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W  = $clog2(MAX_C) + 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             locked_meta;
   logic             locked_s;

   // Two-flop synchroniser; only locked_s is used by the sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= pll_locked;
         locked_s    <= locked_meta;
      end
   end

   // A lock drop in STABLE takes priority over completing the window.
   always_comb begin
      state_nxt = state;
      case (state)
         PLL_RESET: begin
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s)                 state_nxt = STABLE;
            else if (cnt == TIMEOUT_LAST) state_nxt = PLL_RESET;
         end
         STABLE: begin
            if (!locked_s)               state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (!locked_s) state_nxt = PLL_RESET;
         end
         default: state_nxt = PLL_RESET;
      endcase
   end

   // Outputs are registered from the next state so they switch on the same
   // edge as the state register. The counter restarts on every state change
   // and is idle in RUN, where nothing is being timed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= PLL_RESET;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            cnt <= '0;
         else if (state != RUN)
            cnt <= cnt + CNT_W'(1);
         pll_rst   <= (state_nxt == PLL_RESET);
         sys_reset <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
      end
   end

`ifdef PLL_RELOCK_COUNT_EN
   logic [7:0] relock_q;

   // Only lock losses out of RUN are counted; lock timeouts are not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         relock_q <= 8'h00;
      else if ((state == RUN) && (state_nxt == PLL_RESET) && (relock_q != 8'hFF))
         relock_q <= relock_q + 8'd1;
   end

   assign relock_count = relock_q;
`else
   assign relock_count = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Purpose:
//   Self-checking bench for pll_reset_sequencer with RST_CYCLES=4,
//   STABLE_CYCLES=8, LOCK_TIMEOUT=32. A behavioural model described in terms
//   of "reset cycles left", "cycles waited", "consecutive locked cycles" and
//   "running" is compared against the DUT on every falling edge; directed
//   scenarios additionally pin hand-computed values at specific edges
//   counted from reset release (edge 1 = first rising edge after release).
//   Honours PLL_RELOCK_COUNT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int RST_C = 4;
   localparam int TO_C  = 32;
   localparam int ST_C  = 8;

`ifdef PLL_RELOCK_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic [7:0] relock_count;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int base = 0;
   bit chk_en = 1'b0;

   pll_reset_sequencer #(
      .RST_CYCLES   (RST_C),
      .LOCK_TIMEOUT (TO_C),
      .STABLE_CYCLES(ST_C)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .pll_rst     (pll_rst),
      .sys_reset   (sys_reset),
      .ready       (ready),
      .relock_count(relock_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_s1, m_s2, m_run, m_stab;
   int m_rst_left, m_wait, m_stab_n, m_relock;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_run = 1'b0; m_stab = 1'b0;
         m_rst_left = RST_C; m_wait = 0; m_stab_n = 0; m_relock = 0;
      end else begin
         bit ls;
         ls   = m_s2;          // lock as seen by the sequencer before this edge
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (m_run) begin
            if (!ls) begin
               m_run = 1'b0;
               m_rst_left = RST_C;
               if (CNT_EN && m_relock < 255) m_relock++;
            end
         end else if (m_rst_left > 0) begin
            m_rst_left--;
            if (m_rst_left == 0) begin m_wait = 0; m_stab = 1'b0; end
         end else if (!m_stab) begin
            if (ls) begin
               m_stab = 1'b1; m_stab_n = 0;
            end else begin
               m_wait++;
               if (m_wait == TO_C) m_rst_left = RST_C;
            end
         end else begin
            if (!ls) begin
               m_stab = 1'b0; m_wait = 0;
            end else begin
               m_stab_n++;
               if (m_stab_n == ST_C) begin m_run = 1'b1; m_stab = 1'b0; end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("model_pll_rst",   pll_rst,      (m_rst_left > 0) ? 1 : 0);
         check("model_sys_reset", sys_reset,    m_run ? 0 : 1);
         check("model_ready",     ready,        m_run ? 1 : 0);
         check("model_relock",    relock_count, m_relock);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic at_edge(input int k);
      while (cyc < base + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic lk);
      @(negedge clk);
      reset = 1'b1;
      pll_locked = lk;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      base = cyc;
   endtask

   task automatic wait_ready(input int lim);
      int n;
      n = 0;
      while (!ready && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      pll_locked = 1'b1;
      #1 reset = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pll_rst",   pll_rst,      1);
      check("rst_sys_reset", sys_reset,    1);
      check("rst_ready",     ready,        0);
      check("rst_relock",    relock_count, 0);
      reset = 1'b0;
      base = cyc;

      // Lock present from the start: pll_rst falls at 4, RUN at 13.
      at_edge(3);  check("t1_pll_rst_e3",   pll_rst,   1);
      at_edge(4);  check("t1_pll_rst_e4",   pll_rst,   0);
      at_edge(12); check("t1_sys_reset_e12", sys_reset, 1);
      at_edge(13); check("t1_sys_reset_e13", sys_reset, 0);
                   check("t1_ready_e13",     ready,     1);

      // Lock loss in RUN for 3 cycles.
      at_edge(20);
      @(negedge clk); pll_locked = 1'b0;
      at_edge(22); check("t3_sys_reset_e22", sys_reset, 0);
      at_edge(23); check("t3_sys_reset_e23", sys_reset, 1);
                   check("t3_pll_rst_e23",   pll_rst,   1);
      @(negedge clk); pll_locked = 1'b1;
      at_edge(26); check("t3_pll_rst_e26",   pll_rst,   1);
      at_edge(27); check("t3_pll_rst_e27",   pll_rst,   0);
      at_edge(35); check("t3_sys_reset_e35", sys_reset, 1);
      at_edge(36); check("t3_sys_reset_e36", sys_reset, 0);
                   check("t3_relock_e36",    relock_count, CNT_EN ? 1 : 0);

      // No lock: timeout re-resets the PLL every 36 cycles.
      do_reset(1'b0);
      at_edge(1);  check("t2_relock_cleared", relock_count, 0);
      at_edge(35); check("t2_pll_rst_e35", pll_rst, 0);
      at_edge(36); check("t2_pll_rst_e36", pll_rst, 1);
      at_edge(39); check("t2_pll_rst_e39", pll_rst, 1);
      at_edge(40); check("t2_pll_rst_e40", pll_rst, 0);
      at_edge(71); check("t2_pll_rst_e71", pll_rst, 0);
      at_edge(72); check("t2_pll_rst_e72", pll_rst, 1);
                   check("t2_sys_reset_e72", sys_reset, 1);

      // Lock arrives; STABLE from edge 77, 2-cycle dropout near the end.
      @(negedge clk); pll_locked = 1'b1;
      at_edge(82); check("t4_sys_reset_e82", sys_reset, 1);
      @(negedge clk); pll_locked = 1'b0;
      at_edge(84);
      @(negedge clk); pll_locked = 1'b1;
      at_edge(85); check("t4_sys_reset_e85", sys_reset, 1);
                   check("t4_pll_rst_e85",   pll_rst,   0);
      at_edge(90); check("t4_pll_rst_e90",   pll_rst,   0);
      at_edge(94); check("t4_sys_reset_e94", sys_reset, 1);
      at_edge(95); check("t4_sys_reset_e95", sys_reset, 0);
                   check("t4_ready_e95",     ready,     1);

      // Asynchronous reset in the middle of STABLE.
      do_reset(1'b1);
      at_edge(7);  check("t5_pll_rst_e7", pll_rst, 0);
      at_edge(8);
      #2 reset = 1'b1;
      #1;
      check("t5_async_pll_rst",   pll_rst,   1);
      check("t5_async_sys_reset", sys_reset, 1);
      check("t5_async_ready",     ready,     0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      base = cyc;
      at_edge(3);  check("t5_pll_rst_e3",    pll_rst,   1);
      at_edge(4);  check("t5_pll_rst_e4",    pll_rst,   0);
      at_edge(12); check("t5_sys_reset_e12", sys_reset, 1);
      at_edge(13); check("t5_sys_reset_e13", sys_reset, 0);

      // 300 lock losses out of RUN.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); pll_locked = 1'b0;
         repeat (3) @(negedge clk);
         pll_locked = 1'b1;
         wait_ready(60);
      end
      check("t6_relock_sat", relock_count, CNT_EN ? 255 : 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
